// File: rtl/sha256_schedule_stream.sv
// SHA-256 message-schedule streamer: expands a 512-bit block into W[0..63]
// through a 16-word sliding window, emitting one word per handshake.

package sigma_functions;

  function automatic logic [31:0] lower_sigma_zero(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] lower_sigma_one(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

module sha256_schedule_stream (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:511] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [0:31]  w_out,
  output logic [5:0]   w_index,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         w_last
);
  import sigma_functions::*;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] window [16];
  logic [5:0]  t;
  logic        load;
  logic        advance;
  logic [31:0] w_new;

  // Single-stage 4-input add; carries beyond bit 31 are dropped by width.
  assign w_new = lower_sigma_one(window[14]) + window[9]
               + lower_sigma_zero(window[1]) + window[0];

  always_comb begin
    state_next  = state;
    block_ready = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_out       = '0;
    w_index     = '0;
    load        = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        block_ready = 1'b1;
        if (block_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        w_valid = 1'b1;
        w_out   = window[0];
        w_index = t;
        w_last  = (t == 6'd63);
        if (w_ready) begin
          advance = 1'b1;
          if (t == 6'd63) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      for (int unsigned k = 0; k < 16; k++) window[k] <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        t <= '0;
        for (int unsigned k = 0; k < 16; k++) window[k] <= block_in[32*k +: 32];
      end else if (advance) begin
        // t wraps 63 -> 0, leaving the index ready for the next block.
        t <= t + 6'd1;
        for (int unsigned k = 0; k < 15; k++) window[k] <= window[k+1];
        window[15] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_sha256_schedule_stream.sv
// Randomized self-checking bench for sha256_schedule_stream against a
// full 64-entry schedule computed directly from the SHA-256 recurrence.

module tb_sha256_schedule_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:511] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [0:31]  w_out;
  logic [5:0]   w_index;
  logic         w_valid;
  logic         w_ready;
  logic         w_last;

  int n_tests = 0;
  int n_fail  = 0;
  int stream_cycles;
  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];

  sha256_schedule_stream dut (
    .clk        (clk),
    .rst        (rst),
    .block_in   (block_in),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .w_out      (w_out),
    .w_index    (w_index),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_last     (w_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [0:511] blk);
    for (int i = 0; i < 16; i++) exp_w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic rand_block(output logic [0:511] b);
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  // with block_in scrambled to confirm the block was latched.
  task automatic send_block(input logic [0:511] blk);
    int n = 0;
    logic [0:511] junk;
    block_in    = blk;
    block_valid = 1'b1;
    while (!block_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'(n), 64'd0);
    @(negedge clk);
    block_valid = 1'b0;
    rand_block(junk);
    block_in = junk;
  endtask

  // Consumes 64 words with w_ready asserted pct% of cycles; returns at the
  // negedge following the final handshake.
  task automatic receive(input int pct);
    int cnt = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] p_out = '0;
    logic [5:0]  p_idx = '0;
    while (cnt < 64 && cyc < 2000) begin
      if (!w_valid) begin
        check("valid_mid_stream", {63'd0, w_valid}, 64'd1);
        break;
      end
      check("w_out", 64'(w_out), 64'(exp_w[cnt]));
      check("w_index", 64'(w_index), 64'(cnt));
      check("w_last", {63'd0, w_last}, {63'd0, cnt == 63});
      check("ready_in_run", {63'd0, block_ready}, 64'd0);
      if (stalled) check("stall_hold", 64'({w_out, w_index}), 64'({p_out, p_idx}));
      w_ready    = ($urandom_range(0, 99) < pct);
      obs_w[cnt] = w_out;
      p_out      = w_out;
      p_idx      = w_index;
      stalled    = !w_ready;
      if (w_ready) cnt++;
      cyc++;
      @(negedge clk);
    end
    w_ready = 1'b0;
    stream_cycles = cyc;
    check("handshakes", 64'(cnt), 64'd64);
    check("ready_after", {63'd0, block_ready}, 64'd1);
    check("valid_after", {63'd0, w_valid}, 64'd0);
    check("last_after", {63'd0, w_last}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:511] abc;
    logic [0:511] ones;
    logic [0:511] blk_a;
    logic [0:511] blk_b;

    abc  = {32'h61626380, 448'd0, 32'h00000018};
    ones = '1;

    rst = 1'b1; block_valid = 1'b0; w_ready = 1'b0; block_in = '0;
    repeat (3) @(negedge clk);
    check("rst_block_ready", {63'd0, block_ready}, 64'd1);
    check("rst_w_valid", {63'd0, w_valid}, 64'd0);
    check("rst_w_last", {63'd0, w_last}, 64'd0);
    check("rst_w_index", 64'(w_index), 64'd0);
    check("rst_w_out", 64'(w_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // "abc" block, no backpressure: exact timing and known words
    build_model(abc);
    send_block(abc);
    receive(100);
    check("abc_cycles", 64'(stream_cycles), 64'd64);
    check("abc_w0", 64'(obs_w[0]), 64'h61626380);
    check("abc_w15", 64'(obs_w[15]), 64'h00000018);
    check("abc_w16", 64'(obs_w[16]), 64'h61626380);
    check("abc_w17", 64'(obs_w[17]), 64'h000F0000);

    // same block under ~50% backpressure
    send_block(abc);
    receive(50);

    // back-to-back, second block held valid (and ignored) during the first run
    rand_block(blk_a);
    rand_block(blk_b);
    build_model(blk_a);
    send_block(blk_a);
    block_in    = blk_b;
    block_valid = 1'b1;
    receive(100);
    @(negedge clk);
    block_valid = 1'b0;
    build_model(blk_b);
    receive(60);

    // reset mid-stream during a stall at w_index 20
    build_model(abc);
    send_block(abc);
    w_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_rst_index", 64'(w_index), 64'd20);
    w_ready = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_w_valid", {63'd0, w_valid}, 64'd0);
    check("mid_rst_block_ready", {63'd0, block_ready}, 64'd1);
    check("mid_rst_w_index", 64'(w_index), 64'd0);
    check("mid_rst_w_last", {63'd0, w_last}, 64'd0);

    // all-ones block exercises carry drop in the expansion adder
    build_model(ones);
    send_block(ones);
    receive(100);

    for (int r = 0; r < 3; r++) begin
      rand_block(blk_a);
      build_model(blk_a);
      send_block(blk_a);
      receive(int'($urandom_range(30, 100)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
